// File: rtl/fwdpipe_chain_if.sv
// Valid/ready stream with payload; the producer side uses the master modport and
// the consumer side uses the slave modport.
interface fwdpipe_chain_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              valid;
    logic [DWIDTH-1:0] data;
    logic              ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/fwdpipe_chain.sv
// Forward-registered valid/ready pipeline: valid and data are flopped at every stage,
// while ready ripples back combinationally so empty stages absorb bubbles.
module fwdpipe_chain #(
    parameter int unsigned  DWIDTH = 32,
    parameter int unsigned  DEPTH  = 2,
    localparam int unsigned CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    fwdpipe_chain_if.slave    s_if,
    fwdpipe_chain_if.master   m_if,
    output logic [CWIDTH-1:0] occupancy
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("fwdpipe_chain: DEPTH must be in the range 1..16");
    end

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DWIDTH-1:0] dat_q [DEPTH];
    logic [DWIDTH-1:0] dat_d [DEPTH];
    logic [DEPTH-1:0]  rdy;

    // Entry i of each chain is the input of stage i; entry DEPTH is the output side.
    logic [DEPTH:0]    vld_chain;
    logic [DWIDTH-1:0] dat_chain [DEPTH+1];

    assign vld_chain = {vld_q, s_if.valid};

    always_comb begin
        dat_chain[0] = s_if.data;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            dat_chain[i+1] = dat_q[i];
        end
    end

    // A stage can take a beat if it, or any stage downstream of it, is empty, or the
    // consumer is draining the last stage this cycle.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy[i] = m_if.ready | (|(~vld_q >> i));
        end
    end

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                vld_d[i] = vld_chain[i];
                if (vld_chain[i]) begin
                    dat_d[i] = dat_chain[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload needs no reset: it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        dat_q <= dat_d;
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CWIDTH'(vld_q[i]);
        end
    end

    assign s_if.ready = rdy[0];
    assign m_if.valid = vld_chain[DEPTH];
    assign m_if.data  = dat_chain[DEPTH];

endmodule

// File: tb/tb_fwdpipe_chain.sv
// Bench for fwdpipe_chain (DEPTH=3): directed scenarios with fixed expectations plus a
// randomized run checked against a beat-position reference model.
module tb_fwdpipe_chain;

    localparam int DW    = 32;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats in flight, oldest first, with the stage each one sits in.
    logic [DW-1:0] mq_dat[$];
    int            mq_pos[$];

    fwdpipe_chain_if #(.DWIDTH(DW)) up_if ();
    fwdpipe_chain_if #(.DWIDTH(DW)) dn_if ();

    fwdpipe_chain #(
        .DWIDTH(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_if     (up_if),
        .m_if     (dn_if),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic mr);
        up_if.valid = v;
        up_if.data  = d;
        dn_if.ready = mr;
        #1;
    endtask

    // Advance the model by one clock using the current inputs, then step the DUT.
    // A beat moves forward when some stage ahead of it is free or the consumer accepts.
    task automatic tick();
        bit occ[DEPTH];
        bit free;
        bit srdy;
        int p;
        if (!rst_n) begin
            mq_dat.delete();
            mq_pos.delete();
        end else begin
            srdy = (mq_dat.size() < DEPTH) || dn_if.ready;
            foreach (occ[j]) occ[j] = 1'b0;
            foreach (mq_pos[k]) occ[mq_pos[k]] = 1'b1;
            foreach (mq_pos[k]) begin
                p    = mq_pos[k];
                free = dn_if.ready;
                for (int j = p + 1; j < DEPTH; j++) begin
                    if (!occ[j]) free = 1'b1;
                end
                if (free) mq_pos[k] = p + 1;
            end
            if (mq_pos.size() > 0 && mq_pos[0] == DEPTH) begin
                void'(mq_pos.pop_front());
                void'(mq_dat.pop_front());
            end
            if (up_if.valid && srdy) begin
                mq_dat.push_back(up_if.data);
                mq_pos.push_back(0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            n_checks += 3;
            if (dn_if.valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_m_valid: got %b expected 0", dn_if.valid);
            end
            if (occupancy !== CW'(0)) begin
                n_errors++;
                $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
            end
            if (up_if.ready !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_s_ready: got %b expected 1", up_if.ready);
            end
            tick();
        end
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] got[$];
        int first = -1;
        int last  = -1;
        for (int c = 0; c < 23; c++) begin
            drive(c < 16, DW'(c + 1), 1'b1);
            if (dn_if.valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                got.push_back(dn_if.data);
            end
            if (c >= 3 && c <= 16) begin
                n_checks++;
                if (occupancy !== CW'(3)) begin
                    n_errors++;
                    $display("FAIL stream_occupancy: cycle %0d got %0d expected 3", c, occupancy);
                end
            end
            tick();
        end
        n_checks += 3;
        if (first !== 3) begin
            n_errors++;
            $display("FAIL stream_latency: first m_valid cycle got %0d expected 3", first);
        end
        if (last !== 18) begin
            n_errors++;
            $display("FAIL stream_gapless: last m_valid cycle got %0d expected 18", last);
        end
        if (got.size() !== 16) begin
            n_errors++;
            $display("FAIL stream_count: got %0d beats expected 16", got.size());
        end
        foreach (got[k]) begin
            n_checks++;
            if (got[k] !== DW'(k + 1)) begin
                n_errors++;
                $display("FAIL stream_data: beat %0d got %0h expected %0h", k, got[k], k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a_tab[4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        logic [DW-1:0] got[$];
        int idx = 0;
        for (int c = 0; c < 14; c++) begin
            drive(idx < 4, a_tab[idx < 4 ? idx : 0], c >= 6);
            if (c >= 3 && c <= 5) begin
                n_checks += 4;
                if (up_if.ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bp_full_s_ready: cycle %0d got %b expected 0", c, up_if.ready);
                end
                if (occupancy !== CW'(3)) begin
                    n_errors++;
                    $display("FAIL bp_occupancy: cycle %0d got %0d expected 3", c, occupancy);
                end
                if (dn_if.valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_m_valid: cycle %0d got %b expected 1", c, dn_if.valid);
                end
                if (dn_if.data !== 32'hA1) begin
                    n_errors++;
                    $display("FAIL bp_hold_data: cycle %0d got %0h expected a1", c, dn_if.data);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (up_if.ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_release_s_ready: got %b expected 1", up_if.ready);
                end
            end
            if (up_if.valid === 1'b1 && up_if.ready === 1'b1) idx++;
            if (dn_if.valid === 1'b1 && dn_if.ready === 1'b1) got.push_back(dn_if.data);
            tick();
        end
        n_checks++;
        if (got.size() !== 4) begin
            n_errors++;
            $display("FAIL bp_count: got %0d beats expected 4", got.size());
        end
        foreach (got[k]) begin
            n_checks++;
            if (k < 4 && got[k] !== a_tab[k]) begin
                n_errors++;
                $display("FAIL bp_order: beat %0d got %0h expected %0h", k, got[k], a_tab[k]);
            end
        end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] got[$];
        int            cyc[$];
        for (int c = 0; c < 10; c++) begin
            drive(c == 0 || c == 3, c == 0 ? 32'hB1 : 32'hB2, c >= 6);
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (up_if.ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bubble_s_ready: cycle %0d got %b expected 1", c, up_if.ready);
                end
            end
            if (c == 4 || c == 5) begin
                n_checks++;
                if (occupancy !== CW'(2)) begin
                    n_errors++;
                    $display("FAIL bubble_occupancy: cycle %0d got %0d expected 2", c, occupancy);
                end
            end
            if (dn_if.valid === 1'b1 && dn_if.ready === 1'b1) begin
                got.push_back(dn_if.data);
                cyc.push_back(c);
            end
            tick();
        end
        n_checks++;
        if (got.size() !== 2) begin
            n_errors++;
            $display("FAIL bubble_count: got %0d beats expected 2", got.size());
        end else begin
            n_checks += 2;
            if (got[0] !== 32'hB1 || got[1] !== 32'hB2) begin
                n_errors++;
                $display("FAIL bubble_order: got %0h,%0h expected b1,b2", got[0], got[1]);
            end
            if (cyc[0] !== 6 || cyc[1] !== 7) begin
                n_errors++;
                $display("FAIL bubble_timing: got cycles %0d,%0d expected 6,7", cyc[0], cyc[1]);
            end
        end
    endtask

    task automatic test_full_xfer();
        logic [DW-1:0] c_tab[4] = '{32'hC2, 32'hC3, 32'hC4, 32'hC5};
        logic [DW-1:0] got[$];
        int            c5_cyc = -1;
        for (int c = 0; c < 10; c++) begin
            drive(c <= 3, c_tab[c <= 3 ? c : 0], c >= 3);
            if (c == 3) begin
                n_checks += 3;
                if (up_if.ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL full_xfer_s_ready: got %b expected 1", up_if.ready);
                end
                if (occupancy !== CW'(3)) begin
                    n_errors++;
                    $display("FAIL full_xfer_occ_before: got %0d expected 3", occupancy);
                end
                if (dn_if.data !== 32'hC2) begin
                    n_errors++;
                    $display("FAIL full_xfer_head: got %0h expected c2", dn_if.data);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (occupancy !== CW'(3)) begin
                    n_errors++;
                    $display("FAIL full_xfer_occ_after: got %0d expected 3", occupancy);
                end
            end
            if (dn_if.valid === 1'b1 && dn_if.ready === 1'b1) begin
                got.push_back(dn_if.data);
                if (dn_if.data === 32'hC5) c5_cyc = c;
            end
            tick();
        end
        n_checks += 2;
        if (c5_cyc !== 6) begin
            n_errors++;
            $display("FAIL full_xfer_latency: c5 out at cycle %0d expected 6", c5_cyc);
        end
        if (got.size() !== 4) begin
            n_errors++;
            $display("FAIL full_xfer_count: got %0d beats expected 4", got.size());
        end
        foreach (got[k]) begin
            n_checks++;
            if (k < 4 && got[k] !== c_tab[k]) begin
                n_errors++;
                $display("FAIL full_xfer_order: beat %0d got %0h expected %0h", k, got[k], c_tab[k]);
            end
        end
    endtask

    task automatic test_midreset();
        logic [DW-1:0] got[$];
        for (int c = 0; c < 3; c++) begin
            drive(c < 2, c == 0 ? 32'hD1 : 32'hD2, 1'b0);
            if (c == 2) begin
                n_checks++;
                if (occupancy !== CW'(2)) begin
                    n_errors++;
                    $display("FAIL midrst_pre_occ: got %0d expected 2", occupancy);
                end
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (dn_if.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_m_valid: got %b expected 0", dn_if.valid);
        end
        if (occupancy !== CW'(0)) begin
            n_errors++;
            $display("FAIL midrst_occupancy: got %0d expected 0", occupancy);
        end
        mq_dat.delete();
        mq_pos.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1);
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(c == 0, 32'hD0, 1'b1);
            if (c < 3) begin
                n_checks++;
                if (dn_if.valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL midrst_early_valid: cycle %0d got %b expected 0", c, dn_if.valid);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (dn_if.valid !== 1'b1 || dn_if.data !== 32'hD0) begin
                    n_errors++;
                    $display("FAIL midrst_latency: got valid=%b data=%0h expected valid=1 data=d0",
                             dn_if.valid, dn_if.data);
                end
            end
            if (dn_if.valid === 1'b1) got.push_back(dn_if.data);
            tick();
        end
        n_checks++;
        if (got.size() !== 1) begin
            n_errors++;
            $display("FAIL midrst_stale: got %0d beats expected 1", got.size());
        end
    endtask

    task automatic test_random();
        logic exp_rdy;
        logic exp_vld;
        logic mr;
        for (int c = 0; c < 400; c++) begin
            mr = ($urandom_range(0, 9) < 6) || (c >= 390);
            drive(($urandom_range(0, 9) < 7) && (c < 390), $urandom, mr);
            exp_rdy = (mq_dat.size() < DEPTH) || mr;
            exp_vld = (mq_pos.size() > 0) && (mq_pos[0] == DEPTH - 1);
            n_checks += 3;
            if (up_if.ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL rand_s_ready: cycle %0d got %b expected %b", c, up_if.ready, exp_rdy);
            end
            if (dn_if.valid !== exp_vld) begin
                n_errors++;
                $display("FAIL rand_m_valid: cycle %0d got %b expected %b", c, dn_if.valid, exp_vld);
            end
            if (occupancy !== CW'(mq_dat.size())) begin
                n_errors++;
                $display("FAIL rand_occupancy: cycle %0d got %0d expected %0d", c, occupancy,
                         mq_dat.size());
            end
            if (exp_vld) begin
                n_checks++;
                if (dn_if.data !== mq_dat[0]) begin
                    n_errors++;
                    $display("FAIL rand_m_data: cycle %0d got %0h expected %0h", c, dn_if.data,
                             mq_dat[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_full_xfer();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
